// File: rtl/ibex_pkg.sv
// Shared types and constants for the PCS context-save stack.
package ibex_pkg;

    typedef enum logic [1:0] {
        PCS_IDLE  = 2'd0,
        PCS_STORE = 2'd1,
        PCS_LOAD  = 2'd2,
        PCS_DONE  = 2'd3
    } pcs_stack_state_e;

    // Words per context frame: mepc, mcause and 16 ABI caller-saved registers.
    localparam int unsigned PCS_NR_SAVED_REGS = 18;
    localparam int unsigned PCS_STACK_DEPTH   = 4;

endpackage

// File: rtl/rt_ibex_pcs_word_mem.sv
// Word storage for the PCS stack: 1R1W, synchronous write, asynchronous read.
module rt_ibex_pcs_word_mem #(
    parameter int unsigned Words     = 72,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrW     = 7
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AddrW-1:0]     waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [AddrW-1:0]     raddr_i,
    output logic [DataWidth-1:0] rdata_o
);

    logic [DataWidth-1:0] mem_q [Words];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rt_ibex_pcs_seq_stack.sv
// Hardware context stack for PCS interrupts: frames drain into / load from a
// word memory one word per cycle; a pop during a drain short-circuits the shadow.
module rt_ibex_pcs_seq_stack
    import ibex_pkg::*;
#(
    parameter int unsigned NrSavedRegs   = PCS_NR_SAVED_REGS,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned Depth         = PCS_STACK_DEPTH,
    parameter int unsigned IrqLevelWidth = 8
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   push_i,
    input  logic                                   pop_i,
    input  logic [IrqLevelWidth-1:0]               irq_level_i,
    input  logic [NrSavedRegs-1:0][DataWidth-1:0]  store_data_i,
    output logic [NrSavedRegs-1:0][DataWidth-1:0]  restore_data_o,
    output logic                                   restore_en_o,
    output logic [IrqLevelWidth-1:0]               top_level_o,
    output logic                                   ready_o,
    output logic                                   empty_o,
    output logic                                   full_o,
    output logic                                   overflow_o,
    output logic                                   underflow_o,
    output logic                                   drop_o
);

    localparam int unsigned SpW     = $clog2(Depth + 1);
    localparam int unsigned CntW    = (NrSavedRegs > 1) ? $clog2(NrSavedRegs) : 1;
    localparam int unsigned Words   = Depth * NrSavedRegs;
    localparam int unsigned AddrW   = (Words > 1) ? $clog2(Words) : 1;
    localparam int unsigned LvlIdxW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [SpW-1:0]  SpFull  = SpW'(Depth);
    localparam logic [CntW-1:0] CntLast = CntW'(NrSavedRegs - 1);

    typedef logic [NrSavedRegs-1:0][DataWidth-1:0] frame_t;

    pcs_stack_state_e       state_q, state_d;
    logic [SpW-1:0]         sp_q, sp_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    frame_t                 shadow_q, shadow_d;
    frame_t                 restore_data_q, restore_data_d;
    logic [IrqLevelWidth-1:0] lvl_shadow_q, lvl_shadow_d;
    logic [IrqLevelWidth-1:0] top_level_q, top_level_d;
    logic [IrqLevelWidth-1:0] level_q [Depth];
    logic                   abort_q, abort_d;
    logic                   restore_en_q, restore_en_d;
    logic                   ready_q, empty_q, full_q;
    logic                   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;
    logic                   drop_q, drop_d;

    logic                   sp_full_c, sp_empty_c, cnt_last_c;
    logic                   mem_we_c, level_we_c;
    logic [AddrW-1:0]       waddr_c, raddr_c;
    logic [DataWidth-1:0]   mem_rdata_c;

    assign sp_full_c  = (sp_q == SpFull);
    assign sp_empty_c = (sp_q == '0);
    assign cnt_last_c = (cnt_q == CntLast);

    // Drain writes frame sp, load reads frame sp-1.
    assign waddr_c = AddrW'(sp_q) * AddrW'(NrSavedRegs) + AddrW'(cnt_q);
    assign raddr_c = AddrW'(sp_q - SpW'(1)) * AddrW'(NrSavedRegs) + AddrW'(cnt_q);

    rt_ibex_pcs_word_mem #(
        .Words     (Words),
        .DataWidth (DataWidth),
        .AddrW     (AddrW)
    ) u_word_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we_c),
        .waddr_i (waddr_c),
        .wdata_i (shadow_q[cnt_q]),
        .raddr_i (raddr_c),
        .rdata_o (mem_rdata_c)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin : state_reg
        if (rst_i) begin
            state_q <= PCS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            PCS_IDLE: begin
                if (push_i && !sp_full_c) begin
                    state_d = PCS_STORE;
                end else if (pop_i && !push_i && !sp_empty_c) begin
                    state_d = PCS_LOAD;
                end
            end
            PCS_STORE: begin
                if (pop_i) begin
                    state_d = PCS_DONE;
                end else if (cnt_last_c) begin
                    state_d = PCS_IDLE;
                end
            end
            PCS_LOAD: begin
                if (cnt_last_c) begin
                    state_d = PCS_DONE;
                end
            end
            PCS_DONE: state_d = PCS_IDLE;
            default:  state_d = PCS_IDLE;
        endcase
    end

    always_comb begin : outputs
        sp_d           = sp_q;
        cnt_d          = '0;
        shadow_d       = shadow_q;
        lvl_shadow_d   = lvl_shadow_q;
        abort_d        = abort_q;
        restore_en_d   = 1'b0;
        restore_data_d = restore_data_q;
        top_level_d    = top_level_q;
        overflow_d     = overflow_q;
        underflow_d    = underflow_q;
        drop_d         = drop_q;
        mem_we_c       = 1'b0;
        level_we_c     = 1'b0;
        // Counter only advances while staying in a word-sequencing state.
        if ((state_d == state_q) && (state_q == PCS_STORE || state_q == PCS_LOAD)) begin
            cnt_d = cnt_q + CntW'(1);
        end
        case (state_q)
            PCS_IDLE: begin
                if (push_i) begin
                    if (sp_full_c) begin
                        overflow_d = 1'b1;
                    end else begin
                        shadow_d     = store_data_i;
                        lvl_shadow_d = irq_level_i;
                        abort_d      = 1'b0;
                    end
                    if (pop_i) begin
                        drop_d = 1'b1;
                    end
                end else if (pop_i && sp_empty_c) begin
                    underflow_d = 1'b1;
                end
            end
            PCS_STORE: begin
                mem_we_c = 1'b1;
                if (push_i) begin
                    drop_d = 1'b1;
                end
                if (pop_i) begin
                    abort_d        = 1'b1;
                    restore_en_d   = 1'b1;
                    restore_data_d = shadow_q;
                end else if (cnt_last_c) begin
                    sp_d        = sp_q + SpW'(1);
                    top_level_d = lvl_shadow_q;
                    level_we_c  = 1'b1;
                end
            end
            PCS_LOAD: begin
                if (push_i || pop_i) begin
                    drop_d = 1'b1;
                end
                abort_d          = 1'b0;
                shadow_d[cnt_q]  = mem_rdata_c;
                if (cnt_last_c) begin
                    restore_en_d   = 1'b1;
                    restore_data_d = shadow_d;
                end
            end
            PCS_DONE: begin
                if (push_i || pop_i) begin
                    drop_d = 1'b1;
                end
                // An aborted drain never committed its frame, so sp stays.
                if (!abort_q) begin
                    sp_d        = sp_q - SpW'(1);
                    top_level_d = (sp_q > SpW'(1)) ? level_q[LvlIdxW'(sp_q - SpW'(2))] : '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin : data_regs
        if (rst_i) begin
            sp_q           <= '0;
            cnt_q          <= '0;
            shadow_q       <= '0;
            lvl_shadow_q   <= '0;
            abort_q        <= 1'b0;
            restore_en_q   <= 1'b0;
            restore_data_q <= '0;
            top_level_q    <= '0;
            ready_q        <= 1'b1;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            drop_q         <= 1'b0;
            level_q        <= '{default: '0};
        end else begin
            sp_q           <= sp_d;
            cnt_q          <= cnt_d;
            shadow_q       <= shadow_d;
            lvl_shadow_q   <= lvl_shadow_d;
            abort_q        <= abort_d;
            restore_en_q   <= restore_en_d;
            restore_data_q <= restore_data_d;
            top_level_q    <= top_level_d;
            ready_q        <= (state_d == PCS_IDLE);
            empty_q        <= (sp_d == '0);
            full_q         <= (sp_d == SpFull);
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            drop_q         <= drop_d;
            if (level_we_c) begin
                level_q[LvlIdxW'(sp_q)] <= lvl_shadow_q;
            end
        end
    end

    assign restore_data_o = restore_data_q;
    assign restore_en_o   = restore_en_q;
    assign top_level_o    = top_level_q;
    assign ready_o        = ready_q;
    assign empty_o        = empty_q;
    assign full_o         = full_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;
    assign drop_o         = drop_q;

endmodule

// File: tb/tb_rt_ibex_pcs_seq_stack.sv
// Bench for rt_ibex_pcs_seq_stack: directed scenarios plus random push/pop
// traffic, checked against a queue-based stack model.
module tb_rt_ibex_pcs_seq_stack;

    localparam int N  = 18;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int LW = 8;
    localparam int FW = N * W;

    typedef logic [N-1:0][W-1:0] frame_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          push;
    logic          pop;
    logic [LW-1:0] irq_level;
    frame_t        store_data;
    frame_t        restore_data;
    logic          restore_en;
    logic [LW-1:0] top_level;
    logic          ready, empty, full, overflow, underflow, drop;

    rt_ibex_pcs_seq_stack #(
        .NrSavedRegs   (N),
        .DataWidth     (W),
        .Depth         (D),
        .IrqLevelWidth (LW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .push_i         (push),
        .pop_i          (pop),
        .irq_level_i    (irq_level),
        .store_data_i   (store_data),
        .restore_data_o (restore_data),
        .restore_en_o   (restore_en),
        .top_level_o    (top_level),
        .ready_o        (ready),
        .empty_o        (empty),
        .full_o         (full),
        .overflow_o     (overflow),
        .underflow_o    (underflow),
        .drop_o         (drop)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a LIFO of frames and levels plus sticky flags.
    frame_t        m_frames [$];
    logic [LW-1:0] m_levels [$];
    logic          m_ovf, m_unf, m_drop;

    task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic frame_t rand_frame();
        frame_t f;
        for (int k = 0; k < N; k++) f[k] = $urandom;
        return f;
    endfunction

    task automatic model_reset();
        m_frames.delete();
        m_levels.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_drop = 1'b0;
    endtask

    task automatic check_status(input string tag);
        logic [LW-1:0] exp_lvl;
        exp_lvl = (m_levels.size() == 0) ? '0 : m_levels[m_levels.size() - 1];
        chk({tag, "_top_level"}, top_level, exp_lvl);
        chk({tag, "_empty"}, empty, m_frames.size() == 0);
        chk({tag, "_full"}, full, m_frames.size() == D);
        chk({tag, "_overflow"}, overflow, m_ovf);
        chk({tag, "_underflow"}, underflow, m_unf);
        chk({tag, "_drop"}, drop, m_drop);
        chk({tag, "_ready"}, ready, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_restore_en"}, restore_en, 1'b0);
        chk({tag, "_restore_data"}, restore_data, '0);
        chk({tag, "_top_level"}, top_level, '0);
        chk({tag, "_ready"}, ready, 1'b1);
        chk({tag, "_empty"}, empty, 1'b1);
        chk({tag, "_full"}, full, 1'b0);
        chk({tag, "_overflow"}, overflow, 1'b0);
        chk({tag, "_underflow"}, underflow, 1'b0);
        chk({tag, "_drop"}, drop, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        model_reset();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();
    endtask

    // Push a frame; optionally with a same-cycle pop, optionally a stray push mid-drain.
    task automatic do_push(input frame_t f, input logic [LW-1:0] lvl, input bit with_pop, input bit inject);
        int  cyc;
        int  inj_at;
        bit  saw_en;
        bit  full_now;
        full_now   = (m_frames.size() == D);
        inj_at     = $urandom_range(2, N - 2);
        store_data = f;
        irq_level  = lvl;
        push       = 1'b1;
        pop        = with_pop;
        step();
        push       = 1'b0;
        pop        = 1'b0;
        store_data = rand_frame();
        irq_level  = LW'($urandom);
        if (with_pop) m_drop = 1'b1;
        if (full_now) begin
            m_ovf = 1'b1;
            chk("push_full_restore_en", restore_en, 1'b0);
            check_status("push_full");
            return;
        end
        cyc    = 1;
        saw_en = 1'b0;
        while (!ready && cyc < N + 10) begin
            push = (inject && cyc == inj_at);
            step();
            cyc++;
            if (restore_en) saw_en = 1'b1;
        end
        push = 1'b0;
        if (inject) m_drop = 1'b1;
        m_frames.push_back(f);
        m_levels.push_back(lvl);
        chk("push_latency", cyc, N + 1);
        chk("push_no_restore", saw_en, 1'b0);
        check_status("push");
    endtask

    // Pop a frame; optionally a stray push or pop mid-load.
    task automatic do_pop(input bit inject);
        int     cyc;
        int     inj_at;
        bit     inj_push;
        frame_t exp_f;
        if (m_frames.size() == 0) begin
            pop = 1'b1;
            step();
            pop   = 1'b0;
            m_unf = 1'b1;
            chk("pop_empty_restore_en", restore_en, 1'b0);
            step();
            chk("pop_empty_restore_en2", restore_en, 1'b0);
            check_status("pop_empty");
            return;
        end
        exp_f    = m_frames.pop_back();
        void'(m_levels.pop_back());
        inj_at   = $urandom_range(2, N - 1);
        inj_push = $urandom_range(0, 1) == 1;
        pop = 1'b1;
        step();
        pop = 1'b0;
        cyc = 1;
        while (!restore_en && cyc < N + 10) begin
            push = inject && inj_push && (cyc == inj_at);
            pop  = inject && !inj_push && (cyc == inj_at);
            step();
            cyc++;
        end
        push = 1'b0;
        pop  = 1'b0;
        if (inject) m_drop = 1'b1;
        chk("pop_latency", cyc, N + 1);
        chk("pop_data", restore_data, exp_f);
        step();
        chk("pop_strobe_single", restore_en, 1'b0);
        chk("pop_data_hold", restore_data, exp_f);
        check_status("pop");
    endtask

    // Pop during the drain: restore comes straight from the shadow buffer.
    task automatic do_fast(input frame_t f, input logic [LW-1:0] lvl);
        store_data = f;
        irq_level  = lvl;
        push       = 1'b1;
        step();
        push       = 1'b0;
        store_data = rand_frame();
        repeat (4) step();
        pop = 1'b1;
        step();
        pop = 1'b0;
        chk("fast_restore_en", restore_en, 1'b1);
        chk("fast_data", restore_data, f);
        chk("fast_ready_busy", ready, 1'b0);
        step();
        chk("fast_strobe_single", restore_en, 1'b0);
        chk("fast_data_hold", restore_data, f);
        check_status("fast");
    endtask

    task automatic reset_mid_load();
        bit saw_en;
        pop = 1'b1;
        step();
        pop = 1'b0;
        repeat (9) step();
        chk("midload_busy", ready, 1'b0);
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("midload_rst");
        step();
        rst    = 1'b0;
        saw_en = 1'b0;
        repeat (25) begin
            step();
            if (restore_en) saw_en = 1'b1;
        end
        chk("midload_no_restore", saw_en, 1'b0);
        check_status("midload");
    endtask

    initial begin
        frame_t f;
        rst        = 1'b1;
        push       = 1'b0;
        pop        = 1'b0;
        irq_level  = '0;
        store_data = '0;
        model_reset();
        do_reset();

        // Single push then pop.
        for (int k = 0; k < N; k++) f[k] = W'(32'h1000 + k);
        do_push(f, 8'd3, 1'b0, 1'b0);
        do_pop(1'b0);

        // Fill to full, overflow, then LIFO drain.
        for (int i = 0; i < D; i++) do_push(rand_frame(), LW'(i + 5), 1'b0, 1'b0);
        do_push(rand_frame(), 8'd99, 1'b0, 1'b0);
        for (int i = 0; i < D; i++) do_pop(1'b0);

        // Fast path.
        do_fast(rand_frame(), 8'd7);

        // Error cases.
        do_pop(1'b0);
        do_push(rand_frame(), 8'd4, 1'b1, 1'b0);
        do_pop(1'b0);

        // Reset mid-load.
        do_push(rand_frame(), 8'd1, 1'b0, 1'b0);
        do_push(rand_frame(), 8'd2, 1'b0, 1'b0);
        reset_mid_load();

        // Random traffic.
        do_reset();
        for (int n = 0; n < 60; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 4) begin
                do_push(rand_frame(), LW'($urandom), $urandom_range(0, 7) == 0,
                        $urandom_range(0, 5) == 0);
            end else if (op < 8) begin
                do_pop($urandom_range(0, 5) == 0);
            end else if (m_frames.size() < D) begin
                do_fast(rand_frame(), LW'($urandom));
            end else begin
                do_pop(1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rt_ibex_pcs_seq_stack.md
RT_IBEX_PCS_SEQ_STACK -- requirements
Module: rt_ibex_pcs_seq_stack

Interface
REQ-001 The block SHALL take parameter NrSavedRegs, default 18, as the number of words per context frame (2 CSRs + ABI caller-saved registers).
REQ-002 The block SHALL take parameter DataWidth, default 32, as the width of each word.
REQ-003 The block SHALL take parameter Depth, default 4, as the maximum number of stacked frames.
REQ-004 The block SHALL take parameter IrqLevelWidth, default 8, as the width of the interrupt level.
REQ-005 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-006 clk_i  in  1  clock.
REQ-007 rst_i  in  1  asynchronous active-high reset.
REQ-008 push_i  in  1  save request (irq ack of a PCS interrupt).
REQ-009 pop_i  in  1  restore request (next mret while PCS active).
REQ-010 irq_level_i  in  IrqLevelWidth  level of the interrupt being entered.
REQ-011 store_data_i  in  NrSavedRegs x DataWidth  frame to save; word 0 is mepc, word 1 is mcause.
REQ-012 restore_data_o  out  NrSavedRegs x DataWidth  restored frame.
REQ-013 restore_en_o  out  1  one-cycle strobe: restore_data_o is valid and the register file loads it.
REQ-014 top_level_o  out  IrqLevelWidth  level of the top committed frame; 0 when empty.
REQ-015 ready_o  out  1  high in IDLE only.
REQ-016 empty_o, full_o  out  1 each  stack pointer == 0 / == Depth.
REQ-017 overflow_o, underflow_o, drop_o  out  1 each  sticky error flags.

Function
REQ-018 The block SHALL implement the states IDLE, STORE, LOAD and DONE.
REQ-019 Storage SHALL be a single Depth*NrSavedRegs word array, one write and one read per cycle, with address = frame*NrSavedRegs + word.
REQ-020 push_i in IDLE with not full at cycle T SHALL snapshot store_data_i and irq_level_i into a shadow buffer and enter STORE.
REQ-021 STORE SHALL write word k of the shadow buffer in cycle T+1+k, for k = 0..NrSavedRegs-1.
REQ-022 On the last STORE write the stack pointer SHALL increment and the state SHALL return to IDLE (ready_o high at T+NrSavedRegs+1).
REQ-023 pop_i in IDLE with not empty at cycle T SHALL enter LOAD and read word k of frame sp-1 into the shadow buffer in cycle T+1+k.
REQ-024 After the last LOAD read the block SHALL enter DONE, assert restore_en_o for exactly one cycle (T+NrSavedRegs+1) with restore_data_o equal to the shadow buffer, decrement the stack pointer, then return to IDLE.
REQ-025 pop_i during STORE SHALL abort the drain, leave the stack pointer unchanged, assert restore_en_o in the next cycle with the shadow contents, then return to IDLE (fast path).
REQ-026 push_i while full SHALL be ignored and set overflow_o.
REQ-027 pop_i while empty in IDLE SHALL be ignored and set underflow_o.
REQ-028 push_i in STORE, LOAD or DONE SHALL be ignored and set drop_o.
REQ-029 pop_i in LOAD or DONE SHALL be ignored and set drop_o.
REQ-030 Simultaneous push_i and pop_i in IDLE SHALL execute the push and set drop_o.
REQ-031 restore_data_o SHALL hold its value between restore_en_o strobes.
REQ-032 The stack pointer SHALL be $clog2(Depth+1) bits wide and SHALL never wrap.
REQ-033 The word counter SHALL be $clog2(NrSavedRegs) bits wide and clear on every state entry.

Reset
REQ-034 rst_i SHALL act immediately, including mid-STORE or mid-LOAD, and place the block in IDLE with sp=0 and counter=0.
REQ-035 On reset the outputs SHALL be: restore_en_o=0, restore_data_o=0, top_level_o=0, ready_o=1, empty_o=1, full_o=0, overflow_o=0, underflow_o=0, drop_o=0.
REQ-036 Storage array contents SHALL not be reset.

Structure
REQ-037 The state enum pcs_stack_state_e and the default frame depth constant SHALL live in ibex_pkg.
REQ-038 The storage array SHALL be a sub-module rt_ibex_pcs_word_mem (1R1W, synchronous write, asynchronous read) so that a latch or SRAM macro can replace it.
REQ-039 Per-frame irq levels SHALL be held in a separate Depth-entry flop array inside the top module.

Verification
REQ-040 The bench SHALL cover single push then pop: push frame words = 0x1000+k at level 3; pop once ready_o is high -> restore_en_o 19 cycles after pop, data 0x1000+k, empty_o=1.
REQ-041 The bench SHALL cover fill to full: four pushes with distinct frames -> full_o=1, top_level_o equals the last level; a fifth push -> overflow_o=1 and contents unchanged.
REQ-042 The bench SHALL cover LIFO order: push A, B, C; pop three times -> restores return C, B, A; top_level_o tracks each pop.
REQ-043 The bench SHALL cover the fast path: push at T, pop at T+5 -> restore_en_o at T+6 with the pushed frame, sp=0, ready_o=1 at T+7.
REQ-044 The bench SHALL cover error cases: pop while empty -> underflow_o=1; push and pop in the same cycle -> push executed, drop_o=1.
REQ-045 The bench SHALL cover reset mid-LOAD: assert rst_i at word 9 -> restore_en_o never pulses, all outputs at reset values, empty_o=1.
